// File: rtl/kbd_event_fifo.sv
// PS/2 keyboard event FIFO: folds E0/F0 prefix bytes into {brk, ext, code}
// events and queues them for a CPU reader with show-ahead data and a sticky overflow flag.
module kbd_event_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ERR_FLUSH = 1
) (
  input  logic                       clk,
  input  logic                       reset_i,
  input  logic [7:0]                 ps2_kbd_code_i,
  input  logic                       ps2_kbd_strobe_i,
  input  logic                       ps2_kbd_err_i,
  input  logic                       rd_i,
  input  logic                       clr_ovf_i,
  output logic [9:0]                 data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXT  = 2'd1;
  localparam logic [1:0] ST_BRK  = 2'd2;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  logic [1:0]    state_q, state_d;
  logic          ext_q, ext_d;
  logic          emit_c;
  logic [EW-1:0] ev_c;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;

  logic          full_c;
  logic          pop_c;
  logic          wr_en_c;
  logic          drop_c;

  // Prefix decoder: collapses E0/F0 prefixes into a single event.
  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    emit_c  = 1'b0;
    ev_c    = '0;
    if ((ERR_FLUSH != 0) && ps2_kbd_err_i) begin
      state_d = ST_IDLE;
      ext_d   = 1'b0;
    end else if (ps2_kbd_strobe_i) begin
      case (state_q)
        ST_IDLE: begin
          if (ps2_kbd_code_i == CODE_EXT) begin
            state_d = ST_EXT;
          end else if (ps2_kbd_code_i == CODE_BRK) begin
            state_d = ST_BRK;
            ext_d   = 1'b0;
          end else begin
            emit_c = 1'b1;
            ev_c   = {2'b00, ps2_kbd_code_i};
          end
        end
        ST_EXT: begin
          if (ps2_kbd_code_i == CODE_BRK) begin
            state_d = ST_BRK;
            ext_d   = 1'b1;
          end else if (ps2_kbd_code_i != CODE_EXT) begin
            emit_c  = 1'b1;
            ev_c    = {2'b01, ps2_kbd_code_i};
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          if ((ps2_kbd_code_i != CODE_EXT) && (ps2_kbd_code_i != CODE_BRK)) begin
            emit_c  = 1'b1;
            ev_c    = {1'b1, ext_q, ps2_kbd_code_i};
            state_d = ST_IDLE;
            ext_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          ext_d   = 1'b0;
        end
      endcase
    end
  end

  // Queue control: a pop in the same cycle makes room for a push into a full FIFO.
  always_comb begin
    full_c   = (count_q == CW'(DEPTH));
    pop_c    = rd_i && valid_q;
    wr_en_c  = emit_c && (!full_c || pop_c);
    drop_c   = emit_c && full_c && !pop_c;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
    ovf_d   = clr_ovf_i ? 1'b0 : ovf_q;
    if (drop_c) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      ext_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ext_q    <= ext_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_ptr_q] <= ev_c;
    end
  end

  assign data_o     = mem_q[rd_ptr_q];
  assign valid_o    = valid_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_kbd_event_fifo.sv
// Randomised bench for kbd_event_fifo against a queue-based model of
// prefix folding and FIFO behaviour, with literal pins on the directed cases.
module tb_kbd_event_fifo;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic [7:0] ps2_kbd_code_i = 8'h00;
  logic       ps2_kbd_strobe_i = 1'b0;
  logic       ps2_kbd_err_i = 1'b0;
  logic       rd_i = 1'b0;
  logic       clr_ovf_i = 1'b0;
  logic [9:0] data_o;
  logic       valid_o;
  logic [4:0] count_o;
  logic       overflow_o;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  // Model state: pending prefixes and the event queue.
  bit         m_e0 = 1'b0;
  bit         m_f0 = 1'b0;
  bit         m_ovf = 1'b0;
  logic [9:0] mq[$];

  kbd_event_fifo #(.DEPTH(DEPTH), .ERR_FLUSH(1)) dut (
    .clk              (clk),
    .reset_i          (reset_i),
    .ps2_kbd_code_i   (ps2_kbd_code_i),
    .ps2_kbd_strobe_i (ps2_kbd_strobe_i),
    .ps2_kbd_err_i    (ps2_kbd_err_i),
    .rd_i             (rd_i),
    .clr_ovf_i        (clr_ovf_i),
    .data_o           (data_o),
    .valid_o          (valid_o),
    .count_o          (count_o),
    .overflow_o       (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // State the model says must hold after the next rising edge.
  task automatic model_step(input logic [7:0] c, input bit s, input bit e,
                            input bit r, input bit cl, input bit rs);
    bit         emit;
    logic [9:0] ev;
    bit         can_pop;
    emit = 1'b0;
    ev   = '0;
    if (rs) begin
      m_e0 = 1'b0; m_f0 = 1'b0; m_ovf = 1'b0;
      mq.delete();
      return;
    end
    if (e) begin
      m_e0 = 1'b0; m_f0 = 1'b0;
    end else if (s) begin
      if (c == 8'hE0) begin
        if (!m_f0) m_e0 = 1'b1;
      end else if (c == 8'hF0) begin
        m_f0 = 1'b1;
      end else begin
        emit = 1'b1;
        ev   = {m_f0, m_e0, c};
        m_e0 = 1'b0; m_f0 = 1'b0;
      end
    end
    can_pop = r && (mq.size() > 0);
    if (cl) m_ovf = 1'b0;
    if (emit && mq.size() == DEPTH && !can_pop) m_ovf = 1'b1;
    else if (emit) begin
      if (can_pop) void'(mq.pop_front());
      mq.push_back(ev);
    end
    if (can_pop && !emit) void'(mq.pop_front());
  endtask

  // Drive one cycle from a falling edge; returns at the next falling edge.
  task automatic drive(input logic [7:0] c, input bit s, input bit e,
                       input bit r, input bit cl, input bit rs);
    ps2_kbd_code_i   = c;
    ps2_kbd_strobe_i = s;
    ps2_kbd_err_i    = e;
    rd_i             = r;
    clr_ovf_i        = cl;
    reset_i          = rs;
    model_step(c, s, e, r, cl, rs);
    @(negedge clk);
  endtask

  task automatic key(input logic [7:0] c);
    drive(c, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("valid_o", 32'(valid_o), 32'(mq.size() > 0));
      chk("count_o", 32'(count_o), 32'(mq.size()));
      chk("overflow_o", 32'(overflow_o), 32'(m_ovf));
      if (mq.size() > 0) chk("data_o", 32'(data_o), 32'(mq[0]));
    end
  end

  initial begin
    int rd_pct;
    logic [7:0] c;
    @(negedge clk);
    chk_en = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_count", 32'(count_o), 32'd0);
    chk("reset_valid", 32'(valid_o), 32'd0);
    idle();

    key(8'h1C);
    chk("make_1c", 32'(data_o), 32'h01C);
    chk("make_1c_cnt", 32'(count_o), 32'd1);
    pop();

    key(8'hE0); key(8'hF0); key(8'h75);
    chk("ext_brk_75", 32'(data_o), 32'h375);
    pop();
    key(8'hF0); key(8'h1C);
    chk("brk_1c", 32'(data_o), 32'h21C);
    pop();

    key(8'hE0);
    drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    key(8'h75);
    chk("err_flush", 32'(data_o), 32'h075);
    pop();

    key(8'hF0);
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("rst_mid_cnt", 32'(count_o), 32'd0);
    key(8'h1C);
    chk("rst_mid_1c", 32'(data_o), 32'h01C);
    chk("rst_mid_cnt1", 32'(count_o), 32'd1);
    pop();

    for (int i = 1; i <= 17; i++) key(8'(i));
    chk("full_cnt", 32'(count_o), 32'd16);
    chk("full_ovf", 32'(overflow_o), 32'd1);
    chk("full_head", 32'(data_o), 32'h001);
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_ovf", 32'(overflow_o), 32'd0);
    drive(8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("full_pp_cnt", 32'(count_o), 32'd16);
    chk("full_pp_ovf", 32'(overflow_o), 32'd0);
    chk("full_pp_head", 32'(data_o), 32'h002);
    for (int i = 0; i < 15; i++) pop();
    chk("tail_new", 32'(data_o), 32'h022);
    pop();
    chk("drained", 32'(valid_o), 32'd0);
    pop();

    for (int n = 0; n < 3000; n++) begin
      rd_pct = (n < 1500) ? 15 : 60;
      case ($urandom_range(0, 9))
        0:       c = 8'hE0;
        1:       c = 8'hF0;
        default: c = 8'($urandom_range(0, 255));
      endcase
      drive(c, $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < rd_pct, $urandom_range(0, 99) < 5,
            $urandom_range(0, 999) < 4);
    end
    idle();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
